// File: rtl/tt_mux_ctrl_pkg.sv
// tt_mux_ctrl_pkg: state encoding, default timing and helpers for the mux control sequencer.
package tt_mux_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, DIS, SRST, INC_H, INC_L, SETTLE, DONE} state_e;
  localparam int DEF_N_DESIGNS  = 384;
  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_RST_CYCLES = 4;
  localparam int DEF_INC_HI     = 2;
  localparam int DEF_INC_LO     = 2;
  function automatic int clog2_f(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int max3_f(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/tt_mux_ctrl_timer.sv
// tt_mux_ctrl_timer: loadable down-counter that holds at zero and flags it.
module tt_mux_ctrl_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? val : (cnt_q == '0 ? cnt_q : cnt_q - 1'b1);
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign zero = cnt_q == '0;
endmodule

// File: rtl/tt_mux_ctrl_seq.sv
// tt_mux_ctrl_seq: mux control-pin initiator generating sel_rst_n/sel_inc/ena waveforms.
// Define TT_MUX_CTRL_DELTA_INC_EN to increment from the current address instead of always resetting.
module tt_mux_ctrl_seq
  import tt_mux_ctrl_pkg::*;
#(
  parameter int N_DESIGNS  = DEF_N_DESIGNS,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int INC_HI     = DEF_INC_HI,
  parameter int INC_LO     = DEF_INC_LO
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_ena,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc,
  output logic              ctrl_ena
);
  localparam int TW = clog2_f(max3_f(RST_CYCLES, INC_HI, INC_LO) + 1);
  localparam int AW1 = ADDR_W + 1;
  localparam logic [ADDR_W:0] N_LIM = AW1'(N_DESIGNS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_DESIGNS - 1);
  state_e state_q, state_d, dis_next;
  logic [ADDR_W-1:0] tgt_q, cur_q, cur_d, cur_base;
  logic ena_req_q, busy_q, done_q, err_q, rst_n_q, inc_q, ena_q;
  logic accept, addr_ok, tmr_zero, tmr_load;
  logic [TW-1:0] tmr_val;
  assign req_ready = state_q == IDLE && !rst;
  assign accept = req_valid && req_ready;
  assign addr_ok = {1'b0, req_addr} < N_LIM;
`ifdef TT_MUX_CTRL_DELTA_INC_EN
  // Delta stepping is only trusted once an SRST has synchronised the mux counter.
  logic synced_q;
  always_ff @(posedge clk) synced_q <= rst ? 1'b0 : (synced_q || state_q == SRST);
  assign dis_next = (!synced_q || tgt_q < cur_q) ? SRST : (tgt_q == cur_q ? SETTLE : INC_H);
`else
  assign dis_next = SRST;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && addr_ok) state_d = DIS;
      DIS:     state_d = dis_next;
      SRST:    if (tmr_zero) state_d = tgt_q == '0 ? SETTLE : INC_H;
      INC_H:   if (tmr_zero) state_d = INC_L;
      INC_L:   if (tmr_zero) state_d = cur_q == tgt_q ? SETTLE : INC_H;
      SETTLE:  state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // The mux counts on the sel_inc rising edge, so track it on INC_H entry.
  always_comb begin
    cur_base = state_q == SRST ? '0 : cur_q;
    cur_d = (state_d == INC_H && state_q != INC_H && cur_base != LAST) ? cur_base + 1'b1 : cur_base;
    tmr_load = state_d != state_q;
    tmr_val = state_d == SRST ? TW'(RST_CYCLES - 1) :
              state_d == INC_H ? TW'(INC_HI - 1) :
              state_d == INC_L ? TW'(INC_LO - 1) : '0;
  end
  tt_mux_ctrl_timer #(.W(TW)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .val  (tmr_val),
    .zero (tmr_zero)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tgt_q     <= '0;
      cur_q     <= '0;
      ena_req_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rst_n_q   <= 1'b1;
      inc_q     <= 1'b0;
      ena_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      if (accept && addr_ok) begin
        tgt_q     <= req_addr;
        ena_req_q <= req_ena;
      end
      busy_q  <= state_d != IDLE;
      done_q  <= state_d == DONE;
      err_q   <= accept && !addr_ok;
      rst_n_q <= state_d != SRST;
      inc_q   <= state_d == INC_H;
      ena_q   <= state_d == DIS ? 1'b0 : (state_d == SETTLE ? ena_req_q : ena_q);
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
  assign cur_addr = cur_q;
  assign ctrl_sel_rst_n = rst_n_q;
  assign ctrl_sel_inc = inc_q;
  assign ctrl_ena = ena_q;
endmodule

// File: tb/tb_tt_mux_ctrl_seq.sv
// tb_tt_mux_ctrl_seq: directed bench for the mux control sequencer with default timing (4/2/2, 384 designs).
module tb_tt_mux_ctrl_seq;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_ena = 1'b0;
  logic [9:0] req_addr = '0;
  logic [9:0] cur_addr;
  logic req_ready, busy, done, err, ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena;
  int total = 0, bad = 0;
  int mon_done_k, mon_rst_low, mon_pulses, mon_shape, mon_both, mon_ready, mon_end_lo;

  tt_mux_ctrl_seq dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_ena        (req_ena),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .cur_addr       (cur_addr),
    .ctrl_sel_rst_n (ctrl_sel_rst_n),
    .ctrl_sel_inc   (ctrl_sel_inc),
    .ctrl_ena       (ctrl_ena)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    rst = 1'b1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Returns one cycle after the accepting edge (cycle 1 of the sequence).
  task automatic send(input logic [9:0] a, input logic e, input bit hold);
    int w = 0;
    req_valid = 1'b1;
    req_addr = a;
    req_ena = e;
    while (!req_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL send_ready addr=%0d got=%b want=1", a, req_ready); end
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
  endtask

  // Observes from cycle 1 until done; mon_done_k=-1 if done never arrives.
  task automatic monitor(input int budget);
    logic prev_inc = 1'b0;
    int run_hi = 0, run_lo = 0;
    bit seen_fall = 0;
    mon_done_k = -1; mon_rst_low = 0; mon_pulses = 0; mon_shape = 0;
    mon_both = 0; mon_ready = 0; mon_end_lo = 0;
    for (int k = 1; k <= budget; k++) begin
      if (!ctrl_sel_rst_n) mon_rst_low++;
      if (ctrl_sel_inc && !ctrl_sel_rst_n) mon_both++;
      if (req_ready) mon_ready++;
      if (ctrl_sel_inc) begin
        if (!prev_inc) begin
          mon_pulses++;
          if (seen_fall && run_lo != 2) mon_shape++;
        end
        run_hi++;
        run_lo = 0;
      end else begin
        if (prev_inc) begin
          if (run_hi != 2) mon_shape++;
          seen_fall = 1;
        end
        run_hi = 0;
        run_lo++;
      end
      prev_inc = ctrl_sel_inc;
      if (done) begin
        mon_done_k = k;
        mon_end_lo = run_lo;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", req_ready); end
    total++; if ({busy, done, err, ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena} !== 6'b000100) begin bad++; $display("FAIL rst_outs got=%b want=000100", {busy, done, err, ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena}); end
    total++; if (cur_addr !== 10'd0) begin bad++; $display("FAIL rst_cur got=%0d want=0", cur_addr); end
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_addr0;
    send(10'd0, 1'b1, 0);
    monitor(100);
    total++; if (mon_done_k !== 7) begin bad++; $display("FAIL a0_latency got=%0d want=7", mon_done_k); end
    total++; if (mon_rst_low !== 4) begin bad++; $display("FAIL a0_rst_low got=%0d want=4", mon_rst_low); end
    total++; if (mon_pulses !== 0) begin bad++; $display("FAIL a0_pulses got=%0d want=0", mon_pulses); end
    total++; if (ctrl_ena !== 1'b1) begin bad++; $display("FAIL a0_ena got=%b want=1", ctrl_ena); end
    total++; if (cur_addr !== 10'd0) begin bad++; $display("FAIL a0_cur got=%0d want=0", cur_addr); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL a0_busy_at_done got=%b want=1", busy); end
    @(posedge clk); #1;
    total++; if ({busy, done, req_ready} !== 3'b001) begin bad++; $display("FAIL a0_idle got=%b want=001", {busy, done, req_ready}); end
  endtask

  task automatic test_addr5;
    do_reset;
    send(10'd5, 1'b1, 0);
    monitor(200);
    total++; if (mon_done_k !== 27) begin bad++; $display("FAIL a5_latency got=%0d want=27", mon_done_k); end
    total++; if (mon_pulses !== 5) begin bad++; $display("FAIL a5_pulses got=%0d want=5", mon_pulses); end
    total++; if (mon_rst_low !== 4) begin bad++; $display("FAIL a5_rst_low got=%0d want=4", mon_rst_low); end
    total++; if (mon_shape !== 0) begin bad++; $display("FAIL a5_pulse_shape got=%0d bad runs want=0", mon_shape); end
    total++; if (mon_end_lo !== 4) begin bad++; $display("FAIL a5_tail_low got=%0d want=4", mon_end_lo); end
    total++; if (mon_both !== 0) begin bad++; $display("FAIL a5_overlap got=%0d want=0", mon_both); end
    total++; if (cur_addr !== 10'd5) begin bad++; $display("FAIL a5_cur got=%0d want=5", cur_addr); end
    total++; if (ctrl_ena !== 1'b1) begin bad++; $display("FAIL a5_ena got=%b want=1", ctrl_ena); end
    @(posedge clk); #1;
  endtask

  task automatic test_err;
    int tog = 0;
    send(10'd384, 1'b0, 0);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err384_pulse got=%b want=1", err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL err384_busy got=%b want=0", busy); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ctrl_sel_inc || !ctrl_sel_rst_n || !ctrl_ena || busy || err) tog++;
    end
    total++; if (tog !== 0) begin bad++; $display("FAIL err384_quiet got=%0d bad cycles want=0", tog); end
    total++; if (cur_addr !== 10'd5) begin bad++; $display("FAIL err384_cur got=%0d want=5", cur_addr); end
    send(10'd1023, 1'b0, 0);
    total++; if ({err, busy, ctrl_ena} !== 3'b101) begin bad++; $display("FAIL err1023 got=%b want=101", {err, busy, ctrl_ena}); end
    @(posedge clk); #1;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err1023_single got=%b want=0", err); end
  endtask

  task automatic test_mid_reset;
    int p = 0, w = 0;
    logic prev = 1'b0;
    do_reset;
    send(10'd10, 1'b0, 0);
    while (w < 200 && !(p == 4 && ctrl_sel_inc)) begin
      @(posedge clk); #1;
      w++;
      if (ctrl_sel_inc && !prev) p++;
      prev = ctrl_sel_inc;
    end
    total++; if (p !== 4) begin bad++; $display("FAIL mid_reach_pulse4 got=%0d want=4", p); end
    total++; if (cur_addr !== 10'd4) begin bad++; $display("FAIL mid_cur_before got=%0d want=4", cur_addr); end
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if ({req_ready, busy, done, err, ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena} !== 7'b0000100) begin bad++; $display("FAIL mid_rst_outs got=%b want=0000100", {req_ready, busy, done, err, ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena}); end
    total++; if (cur_addr !== 10'd0) begin bad++; $display("FAIL mid_rst_cur got=%0d want=0", cur_addr); end
    rst = 1'b0;
    @(posedge clk); #1;
    send(10'd2, 1'b1, 0);
    monitor(200);
    total++; if (mon_rst_low !== 4) begin bad++; $display("FAIL mid_follow_rst_low got=%0d want=4", mon_rst_low); end
    total++; if (mon_pulses !== 2) begin bad++; $display("FAIL mid_follow_pulses got=%0d want=2", mon_pulses); end
    total++; if (mon_done_k !== 15) begin bad++; $display("FAIL mid_follow_latency got=%0d want=15", mon_done_k); end
    total++; if (cur_addr !== 10'd2) begin bad++; $display("FAIL mid_follow_cur got=%0d want=2", cur_addr); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    do_reset;
    send(10'd1, 1'b0, 1);
    req_addr = 10'd3;
    req_ena = 1'b1;
    monitor(100);
    total++; if (mon_done_k !== 11) begin bad++; $display("FAIL b2b_first_latency got=%0d want=11", mon_done_k); end
    total++; if (mon_ready !== 0) begin bad++; $display("FAIL b2b_ready_while_busy got=%0d cycles want=0", mon_ready); end
    total++; if (ctrl_ena !== 1'b0) begin bad++; $display("FAIL b2b_first_ena got=%b want=0", ctrl_ena); end
    @(posedge clk); #1;
    total++; if ({req_ready, busy} !== 2'b10) begin bad++; $display("FAIL b2b_idle_gap got=%b want=10", {req_ready, busy}); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++; if ({req_ready, busy} !== 2'b01) begin bad++; $display("FAIL b2b_second_accept got=%b want=01", {req_ready, busy}); end
    monitor(200);
`ifdef TT_MUX_CTRL_DELTA_INC_EN
    total++; if (mon_done_k !== 11) begin bad++; $display("FAIL b2b_second_latency got=%0d want=11", mon_done_k); end
    total++; if (mon_pulses !== 2) begin bad++; $display("FAIL b2b_second_pulses got=%0d want=2", mon_pulses); end
`else
    total++; if (mon_done_k !== 19) begin bad++; $display("FAIL b2b_second_latency got=%0d want=19", mon_done_k); end
    total++; if (mon_pulses !== 3) begin bad++; $display("FAIL b2b_second_pulses got=%0d want=3", mon_pulses); end
`endif
    total++; if ({cur_addr, ctrl_ena} !== {10'd3, 1'b1}) begin bad++; $display("FAIL b2b_second_result got=%0d/%b want=3/1", cur_addr, ctrl_ena); end
    @(posedge clk); #1;
  endtask

`ifdef TT_MUX_CTRL_DELTA_INC_EN
  task automatic test_delta;
    do_reset;
    send(10'd3, 1'b1, 0);
    monitor(200);
    total++; if (mon_done_k !== 19) begin bad++; $display("FAIL d3_latency got=%0d want=19", mon_done_k); end
    @(posedge clk); #1;
    send(10'd7, 1'b1, 0);
    monitor(200);
    total++; if (mon_rst_low !== 0) begin bad++; $display("FAIL d7_rst_low got=%0d want=0", mon_rst_low); end
    total++; if (mon_pulses !== 4) begin bad++; $display("FAIL d7_pulses got=%0d want=4", mon_pulses); end
    total++; if (mon_done_k !== 19) begin bad++; $display("FAIL d7_latency got=%0d want=19", mon_done_k); end
    total++; if (cur_addr !== 10'd7) begin bad++; $display("FAIL d7_cur got=%0d want=7", cur_addr); end
    @(posedge clk); #1;
    send(10'd1, 1'b1, 0);
    monitor(200);
    total++; if (mon_rst_low !== 4) begin bad++; $display("FAIL d1_rst_low got=%0d want=4", mon_rst_low); end
    total++; if (mon_pulses !== 1) begin bad++; $display("FAIL d1_pulses got=%0d want=1", mon_pulses); end
    total++; if (mon_done_k !== 11) begin bad++; $display("FAIL d1_latency got=%0d want=11", mon_done_k); end
    total++; if (cur_addr !== 10'd1) begin bad++; $display("FAIL d1_cur got=%0d want=1", cur_addr); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset;
    test_addr0;
    test_addr5;
    test_err;
    test_mid_reset;
    test_back_to_back;
`ifdef TT_MUX_CTRL_DELTA_INC_EN
    test_delta;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
